// File: rtl/demux_pkg.sv
// Shared definitions for the 4-way stream demultiplexer.
// Holds the channel count, the select type and the select-to-push-enable decode.
package demux_pkg;

  localparam int NCH = 4;

  typedef logic [1:0] chan_sel_t;

  function automatic logic [NCH-1:0] onehot4(input chan_sel_t sel);
    onehot4 = NCH'(1) << sel;
  endfunction

endpackage

// File: rtl/chan_fifo.sv
// Per-channel FIFO for demux4_stream: register-array storage, wrapping pointers,
// and an occupancy count that separates full from empty.
module chan_fifo
  import demux_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic             full,
  output logic             empty,
  output logic [WIDTH-1:0] head_data
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH) + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             do_push, do_pop;

  assign full    = (count_q == CW'(DEPTH));
  assign empty   = (count_q == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  // Power-of-two depth lets the pointers wrap by natural overflow.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      if (do_push) mem_q[wr_ptr_q] <= push_data;
    end
  end

  assign head_data = mem_q[rd_ptr_q];

endmodule

// File: rtl/demux4_stream.sv
// Routes one valid/ready stream to four independently buffered output channels.
// Only the select decode, the in_ready mux and the accepted-beat counter live here.
module demux4_stream
  import demux_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int DEPTH = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [WIDTH-1:0]     in_data,
  input  logic [1:0]           in_sel,
  input  logic                 in_valid,
  output logic                 in_ready,
  output logic [NCH*WIDTH-1:0] out_data,
  output logic [NCH-1:0]       out_valid,
  input  logic [NCH-1:0]       out_ready,
  output logic [7:0]           accepted_count
);

  logic [NCH-1:0] full_v, empty_v, push_v, pop_v;
  logic           accept;
  logic [7:0]     accepted_count_q, accepted_count_d;

  // A full channel stalls only beats addressed to it.
  assign in_ready = !reset && !full_v[in_sel];
  assign accept   = in_valid && in_ready;
  assign push_v   = onehot4(chan_sel_t'(in_sel)) & {NCH{accept}};
  assign pop_v    = out_valid & out_ready;

  for (genvar i = 0; i < NCH; i++) begin : g_ch
    chan_fifo #(
      .WIDTH(WIDTH),
      .DEPTH(DEPTH)
    ) u_fifo (
      .clk      (clk),
      .reset    (reset),
      .push     (push_v[i]),
      .push_data(in_data),
      .pop      (pop_v[i]),
      .full     (full_v[i]),
      .empty    (empty_v[i]),
      .head_data(out_data[i*WIDTH +: WIDTH])
    );
  end

  assign out_valid = ~empty_v;

  always_comb begin
    accepted_count_d = accepted_count_q;
    if (accept) accepted_count_d = accepted_count_q + 8'd1;
  end

  always_ff @(posedge clk) begin
    if (reset) accepted_count_q <= '0;
    else       accepted_count_q <= accepted_count_d;
  end

  assign accepted_count = accepted_count_q;

endmodule
